ram_burst_reader: RTL and testbench



---
 rtl/ram_burst_reader.sv | 176 +++++++++++++++++
 tb/tb_ram_burst_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: sweeps the result RAM from address 0 to max_ram_address-1
// and unpacks every burst word into burst_index samples, slot 0 first,
// presented on a valid/ready stream.
//
// Ports:
//   clk           clock, shared with the RAM read port
//   reset         asynchronous active-low reset
//   start         one-cycle pulse, begins a sweep (ignored unless idle)
//   ram_addr      RAM read address
//   ram_q         RAM read data (read_latency cycles after ram_addr)
//   sample_data   unpacked sample
//   sample_valid  sample_data valid
//   sample_ready  downstream accepts when high together with sample_valid
//   sample_index  samples accepted so far in this sweep
//   busy          sweep in progress
//   done          high from sweep completion until the next start
module ram_burst_reader #(
    parameter int unsigned no_of_digits    = 10,
    parameter int unsigned radix_bits      = 3,
    parameter int unsigned address_width   = 14,
    parameter int unsigned max_ram_address = 4096,
    parameter int unsigned burst_index     = 5,
    parameter int unsigned read_latency    = 2
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    output logic [address_width-1:0]                              ram_addr,
    input  logic [(no_of_digits+1)*radix_bits*burst_index-1:0]    ram_q,
    output logic [(no_of_digits+1)*radix_bits-1:0]                sample_data,
    output logic                                                  sample_valid,
    input  logic                                                  sample_ready,
    output logic [address_width+8-1:0]                            sample_index,
    output logic                                                  busy,
    output logic                                                  done
);

    localparam int unsigned SW     = (no_of_digits + 1) * radix_bits;
    localparam int unsigned WW     = SW * burst_index;
    localparam int unsigned AW     = address_width;
    localparam int unsigned IDX_W  = address_width + 8;
    localparam int unsigned SLOT_W = (burst_index > 1) ? $clog2(burst_index) : 1;
    localparam int unsigned LAT_W  = (read_latency > 1) ? $clog2(read_latency) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t              state_q,        state_d;
    logic [AW-1:0]       ram_addr_q,     ram_addr_d;
    logic [WW-1:0]       burst_q,        burst_d;
    logic [SLOT_W-1:0]   slot_q,         slot_d;
    logic [LAT_W-1:0]    lat_q,          lat_d;
    logic [SW-1:0]       sample_data_q,  sample_data_d;
    logic                sample_valid_q, sample_valid_d;
    logic [IDX_W-1:0]    sample_index_q, sample_index_d;
    logic                busy_q,         busy_d;
    logic                done_q,         done_d;

    logic [SW-1:0]       slot_word [burst_index];
    logic [SLOT_W-1:0]   slot_nxt;

    // Burst register viewed as an array of samples, slot 0 in the low bits
    for (genvar k = 0; k < burst_index; k++) begin : g_slot
        assign slot_word[k] = burst_q[k*SW +: SW];
    end

    assign slot_nxt = slot_q + SLOT_W'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        ram_addr_d     = ram_addr_q;
        burst_d        = burst_q;
        slot_d         = slot_q;
        lat_d          = lat_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        sample_index_d = sample_index_q;
        busy_d         = busy_q;
        done_d         = done_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ram_addr_d     = '0;
                    sample_index_d = '0;
                    done_d         = 1'b0;
                    busy_d         = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_W'(read_latency - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    // Slot 0 goes straight from ram_q so valid rises with the capture
                    burst_d        = ram_q;
                    slot_d         = '0;
                    sample_data_d  = ram_q[SW-1:0];
                    sample_valid_d = 1'b1;
                    state_d        = EMIT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            EMIT: begin
                if (sample_valid_q && sample_ready) begin
                    sample_index_d = sample_index_q + IDX_W'(1);
                    if (slot_q == SLOT_W'(burst_index - 1)) begin
                        sample_valid_d = 1'b0;
                        if (ram_addr_q == AW'(max_ram_address - 1)) begin
                            state_d = FINISH;
                        end else begin
                            ram_addr_d = ram_addr_q + AW'(1);
                            state_d    = ISSUE;
                        end
                    end else begin
                        slot_d        = slot_nxt;
                        sample_data_d = slot_word[slot_nxt];
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ram_addr_q     <= '0;
            burst_q        <= '0;
            slot_q         <= '0;
            lat_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            sample_index_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ram_addr_q     <= ram_addr_d;
            burst_q        <= burst_d;
            slot_q         <= slot_d;
            lat_q          <= lat_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            sample_index_q <= sample_index_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign sample_index = sample_index_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: three instances with read_latency 1, 2 and 3,
// each fed by a pipelined RAM model, driven through directed sweeps with
// random backpressure and checked against the sample list derived from the
// RAM contents.
module tb_ram_burst_reader;

    localparam int unsigned ND   = 10;
    localparam int unsigned RB   = 3;
    localparam int unsigned AW   = 14;
    localparam int unsigned MAXA = 4;
    localparam int unsigned BI   = 5;
    localparam int unsigned SW   = (ND + 1) * RB;
    localparam int unsigned WW   = SW * BI;
    localparam int unsigned IW   = AW + 8;
    localparam int          NS   = MAXA * BI;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]           start_s;
    logic [2:0]           rdy_s;
    logic [2:0][AW-1:0]   addr_w;
    logic [2:0][WW-1:0]   rq;
    logic [2:0][SW-1:0]   sd_w;
    logic [2:0]           sv_w;
    logic [2:0][IW-1:0]   si_w;
    logic [2:0]           busy_w;
    logic [2:0]           done_w;

    logic [WW-1:0]        mem [MAXA];
    logic [SW-1:0]        exp_q [$];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        logic [WW-1:0] pipe [LAT];

        // RAM read port: data appears LAT cycles after the address changes
        always @(posedge clk) begin
            pipe[0] <= mem[addr_w[g][1:0]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rq[g] = pipe[LAT-1];

        ram_burst_reader #(
            .no_of_digits   (ND),
            .radix_bits     (RB),
            .address_width  (AW),
            .max_ram_address(MAXA),
            .burst_index    (BI),
            .read_latency   (LAT)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start_s[g]),
            .ram_addr    (addr_w[g]),
            .ram_q       (rq[g]),
            .sample_data (sd_w[g]),
            .sample_valid(sv_w[g]),
            .sample_ready(rdy_s[g]),
            .sample_index(si_w[g]),
            .busy        (busy_w[g]),
            .done        (done_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Fill RAM and build the expected capture-order sample list
    task automatic load_ram(input bit rnd);
        logic [WW-1:0] word;
        logic [SW-1:0] v;
        exp_q.delete();
        for (int a = 0; a < MAXA; a++) begin
            word = '0;
            for (int k = 0; k < BI; k++) begin
                v = rnd ? SW'({$urandom, $urandom}) : SW'(16 * a + k);
                word[k*SW +: SW] = v;
                exp_q.push_back(v);
            end
            mem[a] = word;
        end
    endtask

    task automatic chk_zero(input logic [1:0] d, input string tag);
        chk({tag, "_addr"},  64'(addr_w[d]), 64'(0));
        chk({tag, "_data"},  64'(sd_w[d]),   64'(0));
        chk({tag, "_valid"}, 64'(sv_w[d]),   64'(0));
        chk({tag, "_index"}, 64'(si_w[d]),   64'(0));
        chk({tag, "_busy"},  64'(busy_w[d]), 64'(0));
        chk({tag, "_done"},  64'(done_w[d]), 64'(0));
    endtask

    // One sweep on instance d; pct = ready probability in percent,
    // exp_first = expected first-valid cycle (0 skips), rst_after / start_at
    // = accepted-sample count at which to reset / pulse start (-1 disables).
    task automatic sweep(input logic [1:0] d, input int pct, input int exp_first,
                         input int rst_after, input int start_at);
        int acc, cyc, n, pulse, lo;
        bit first_seen, hold, rdy;
        logic [SW-1:0] held;
        acc = 0; cyc = 0; pulse = 0; first_seen = 0; hold = 0; held = '0;
        @(negedge clk);
        start_s[d] = 1'b1;
        rdy_s[d]   = 1'b0;
        @(negedge clk);
        start_s[d] = 1'b0;
        cyc = 1;
        while (acc < NS && cyc < 2000) begin
            if (pulse == 1) begin
                start_s[d] = 1'b0;
                pulse = 2;
            end
            if (start_at >= 0 && acc == start_at && pulse == 0) begin
                start_s[d] = 1'b1;
                pulse = 1;
            end
            chk("busy_during", 64'(busy_w[d]), 64'(1));
            chk("done_during", 64'(done_w[d]), 64'(0));
            if (hold) begin
                chk("hold_valid", 64'(sv_w[d]), 64'(1));
                chk("hold_data",  64'(sd_w[d]), 64'(held));
            end
            if (sv_w[d] && !first_seen) begin
                first_seen = 1;
                if (exp_first > 0) chk("first_valid_cycle", 64'(cyc), 64'(exp_first));
            end
            rdy = ($urandom_range(99) < pct);
            rdy_s[d] = rdy;
            hold = sv_w[d] && !rdy;
            held = sd_w[d];
            if (sv_w[d] && rdy) begin
                chk("sample_index", 64'(si_w[d]), 64'(acc));
                chk("sample_data",  64'(sd_w[d]), 64'(exp_q[acc]));
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (rst_after >= 0 && acc == rst_after) begin
                reset = 1'b0;
                rdy_s[d] = 1'b0;
                #1;
                chk_zero(d, "mid_reset");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        chk("sweep_complete", 64'(acc), 64'(NS));
        rdy_s[d] = 1'b0;
        n = 0;
        while (!done_w[d] && n < 12) begin
            @(negedge clk);
            cyc++;
            n++;
        end
        chk("done_end",  64'(done_w[d]), 64'(1));
        chk("busy_end",  64'(busy_w[d]), 64'(0));
        chk("valid_end", 64'(sv_w[d]),   64'(0));
        chk("index_end", 64'(si_w[d]),   64'(NS));
        if (pct == 100) begin
            lo = MAXA * (BI + int'(d) + 2) + 1;
            chk("sweep_cycles", 64'(cyc >= lo && cyc <= lo + 2), 64'(1));
        end
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", 64'(done_w[d]), 64'(1));
            chk("idle_busy", 64'(busy_w[d]), 64'(0));
        end
    endtask

    initial begin
        reset   = 1'b0;
        start_s = '0;
        rdy_s   = '0;
        load_ram(1'b0);
        repeat (5) @(negedge clk);
        chk_zero(2'd1, "in_reset");
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk_zero(2'(d), "idle");
        end

        sweep(2'd1, 100, 4, -1, -1);
        sweep(2'd1, 30,  0, -1, -1);
        sweep(2'd0, 50,  3, -1, -1);
        sweep(2'd2, 50,  5, -1, -1);
        sweep(2'd0, 100, 3, -1, -1);
        sweep(2'd1, 100, 0, 7,  -1);
        sweep(2'd1, 100, 4, -1, -1);
        sweep(2'd1, 100, 0, -1, 9);

        load_ram(1'b1);
        for (int d = 0; d < 3; d++) sweep(2'(d), 60, d + 3, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
